// File: rtl/hwpe_tcdm_wide_responder_if.sv
// Wide-request / per-bank-lane bus bundle between an HWPE streamer and the TCDM banks.
// Suffixes are seen from the responder: slave is the responder, master is its environment.
interface hwpe_tcdm_wide_responder_if #(
    parameter int HwpeDataWidth = 512,
    parameter int TCDMDataWidth = 64,
    parameter int AddrWidth     = 32
);
    localparam int NrPorts = HwpeDataWidth / TCDMDataWidth;

    logic                           wide_q_valid_i;
    logic                           wide_q_ready_o;
    logic [AddrWidth-1:0]           wide_q_addr_i;
    logic                           wide_q_write_i;
    logic [HwpeDataWidth/8-1:0]     wide_q_strb_i;
    logic [HwpeDataWidth-1:0]       wide_q_data_i;
    logic                           wide_p_valid_o;
    logic [HwpeDataWidth-1:0]       wide_p_data_o;
    logic [NrPorts-1:0]             bank_q_valid_o;
    logic [NrPorts-1:0]             bank_q_ready_i;
    logic [NrPorts*AddrWidth-1:0]   bank_q_addr_o;
    logic [NrPorts-1:0]             bank_q_write_o;
    logic [HwpeDataWidth/8-1:0]     bank_q_strb_o;
    logic [HwpeDataWidth-1:0]       bank_q_data_o;
    logic [NrPorts-1:0]             bank_p_valid_i;
    logic [HwpeDataWidth-1:0]       bank_p_data_i;

    modport slave (
        input  wide_q_valid_i, wide_q_addr_i, wide_q_write_i, wide_q_strb_i, wide_q_data_i,
        input  bank_q_ready_i, bank_p_valid_i, bank_p_data_i,
        output wide_q_ready_o, wide_p_valid_o, wide_p_data_o,
        output bank_q_valid_o, bank_q_addr_o, bank_q_write_o, bank_q_strb_o, bank_q_data_o
    );

    modport master (
        output wide_q_valid_i, wide_q_addr_i, wide_q_write_i, wide_q_strb_i, wide_q_data_i,
        output bank_q_ready_i, bank_p_valid_i, bank_p_data_i,
        input  wide_q_ready_o, wide_p_valid_o, wide_p_data_o,
        input  bank_q_valid_o, bank_q_addr_o, bank_q_write_o, bank_q_strb_o, bank_q_data_o
    );
endinterface

// File: rtl/hwpe_tcdm_wide_responder.sv
// Splits one wide TCDM access into per-bank lanes and merges the lane responses into one pulse.
// Response two cycles after the final lane grant; wide request held off until every needed lane is granted.
module hwpe_tcdm_wide_responder #(
    parameter int HwpeDataWidth = 512,
    parameter int TCDMDataWidth = 64,
    parameter int AddrWidth     = 32
) (
    input logic                       clk_i,
    input logic                       rst_i,
    hwpe_tcdm_wide_responder_if.slave bus
);
    localparam int NrPorts   = HwpeDataWidth / TCDMDataWidth;
    localparam int LaneBytes = TCDMDataWidth / 8;
    localparam int WideBytes = HwpeDataWidth / 8;

    typedef enum logic [1:0] {StIssue, StCollect, StRespond} state_e;

    state_e                   state_q, state_d;
    logic [NrPorts-1:0]       gnt_q, gnt_d;
    logic [NrPorts-1:0]       pend_q, pend_d;
    logic [NrPorts-1:0]       resp_q, resp_d;
    logic [NrPorts-1:0]       need_q, need_d;
    logic                     write_q, write_d;
    logic [HwpeDataWidth-1:0] rbuf_q, rbuf_d;

    logic [NrPorts-1:0]       need_now, grants, rsp_now, bank_vld;
    logic                     wide_rdy;
    logic [AddrWidth-1:0]     base_addr;

    assign base_addr = bus.wide_q_addr_i & ~AddrWidth'(WideBytes - 1);

    for (genvar g = 0; g < NrPorts; g++) begin : g_lane
        assign bus.bank_q_addr_o[g*AddrWidth +: AddrWidth] = base_addr + AddrWidth'(g * LaneBytes);
    end

    assign bus.bank_q_strb_o  = bus.wide_q_strb_i;
    assign bus.bank_q_data_o  = bus.wide_q_data_i;
    assign bus.bank_q_write_o = {NrPorts{bus.wide_q_write_i}};
    assign bus.bank_q_valid_o = bank_vld;
    assign bus.wide_q_ready_o = wide_rdy;
    assign bus.wide_p_valid_o = (state_q == StRespond);
    assign bus.wide_p_data_o  = (state_q == StRespond && !write_q) ? rbuf_q : '0;

    always_comb begin
        need_now = '0;
        for (int i = 0; i < NrPorts; i++) begin
            need_now[i] = !bus.wide_q_write_i || (|bus.wide_q_strb_i[i*LaneBytes +: LaneBytes]);
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        need_d   = need_q;
        write_d  = write_q;
        rbuf_d   = rbuf_q;
        bank_vld = '0;
        grants   = '0;
        wide_rdy = 1'b0;

        // Only lanes with a grant still outstanding may deliver data.
        rsp_now = bus.bank_p_valid_i & pend_q;
        for (int i = 0; i < NrPorts; i++) begin
            if (rsp_now[i]) begin
                rbuf_d[i*TCDMDataWidth +: TCDMDataWidth] = bus.bank_p_data_i[i*TCDMDataWidth +: TCDMDataWidth];
            end
        end
        resp_d = resp_q | rsp_now;

        case (state_q)
            StIssue: begin
                if (bus.wide_q_valid_i && !rst_i) begin
                    bank_vld = need_now & ~gnt_q;
                    grants   = bank_vld & bus.bank_q_ready_i;
                    gnt_d    = gnt_q | grants;
                    if (&(gnt_q | grants | ~need_now)) begin
                        wide_rdy = 1'b1;
                        gnt_d    = '0;
                        need_d   = need_now;
                        write_d  = bus.wide_q_write_i;
                        // A write touching no lane has nothing to wait for.
                        state_d  = (&(resp_d | ~need_now)) ? StRespond : StCollect;
                    end
                end
            end
            StCollect: begin
                if (&(resp_d | ~need_q)) begin
                    state_d = StRespond;
                end
            end
            StRespond: begin
                state_d = StIssue;
                resp_d  = '0;
                rbuf_d  = '0;
            end
            default: state_d = StIssue;
        endcase

        pend_d = (pend_q & ~bus.bank_p_valid_i) | grants;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIssue;
            gnt_q   <= '0;
            pend_q  <= '0;
            resp_q  <= '0;
            need_q  <= '0;
            write_q <= 1'b0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            pend_q  <= pend_d;
            resp_q  <= resp_d;
            need_q  <= need_d;
            write_q <= write_d;
            rbuf_q  <= rbuf_d;
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) (bus.bank_p_valid_i & ~pend_q) == '0);

endmodule

// File: tb/tb_hwpe_tcdm_wide_responder.sv
// Directed bench for hwpe_tcdm_wide_responder at default parameters (8 lanes x 64 bit).
module tb_hwpe_tcdm_wide_responder;
    logic clk;
    logic rst;
    logic [511:0] bank_pat;
    logic [511:0] p1, p2, p3, p4, p5;
    int ncmp;
    int nfail;

    hwpe_tcdm_wide_responder_if bus ();

    hwpe_tcdm_wide_responder dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] mkpat(input logic [31:0] seed);
        logic [511:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            p[i*64 +: 64] = {seed + 32'(i), ~seed ^ 32'(i)};
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Bank side: every lane granted before an edge answers in the following cycle.
    task automatic tick();
        logic [7:0] g;
        #1;
        g = bus.bank_q_valid_o & bus.bank_q_ready_i;
        @(posedge clk);
        #1;
        bus.bank_p_valid_i = g;
        bus.bank_p_data_i  = bank_pat;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        ncmp  = 0;
        nfail = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        p1 = mkpat(32'h1111_0000);
        p2 = mkpat(32'h2222_0000);
        p3 = mkpat(32'h3333_0000);
        p4 = mkpat(32'h4444_0000);
        p5 = mkpat(32'h5555_0000);
        bank_pat = p1;
        bus.wide_q_valid_i = 1'b1;
        bus.wide_q_addr_i  = 32'h0000_1000;
        bus.wide_q_write_i = 1'b0;
        bus.wide_q_strb_i  = '1;
        bus.wide_q_data_i  = '0;
        bus.bank_q_ready_i = '1;
        bus.bank_p_valid_i = '0;
        bus.bank_p_data_i  = '0;

        // Reset held with a pending request must keep everything quiet.
        tick();
        tick();
        settle();
        chk("rst_wide_rdy", 512'(bus.wide_q_ready_o), 512'(0));
        chk("rst_bank_vld", 512'(bus.bank_q_valid_o), 512'(0));
        chk("rst_p_vld",    512'(bus.wide_p_valid_o), 512'(0));
        chk("rst_p_dat",    bus.wide_p_data_o, 512'(0));
        bus.wide_q_valid_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Read at 0x1000, all banks ready.
        bus.wide_q_valid_i = 1'b1;
        bus.wide_q_addr_i  = 32'h0000_1000;
        bus.wide_q_write_i = 1'b0;
        settle();
        chk("t1_bank_vld",   512'(bus.bank_q_valid_o), 512'(8'hFF));
        chk("t1_wide_rdy",   512'(bus.wide_q_ready_o), 512'(1));
        chk("t1_lane0_addr", 512'(bus.bank_q_addr_o[0*32 +: 32]), 512'(32'h1000));
        chk("t1_lane7_addr", 512'(bus.bank_q_addr_o[7*32 +: 32]), 512'(32'h1038));
        tick();
        bus.wide_q_valid_i = 1'b0;
        settle();
        chk("t1_p_vld_t1",   512'(bus.wide_p_valid_o), 512'(0));
        tick();
        settle();
        chk("t1_p_vld_t2",   512'(bus.wide_p_valid_o), 512'(1));
        chk("t1_p_dat_t2",   bus.wide_p_data_o, p1);
        tick();
        settle();
        chk("t1_p_vld_t3",   512'(bus.wide_p_valid_o), 512'(0));
        chk("t1_p_dat_t3",   bus.wide_p_data_o, 512'(0));

        // Split grant: lanes 0-3 now, 4-7 two cycles later; unaligned address.
        bank_pat = p2;
        bus.wide_q_valid_i = 1'b1;
        bus.wide_q_addr_i  = 32'h0000_2010;
        bus.bank_q_ready_i = 8'h0F;
        settle();
        chk("t2_bank_vld_t0", 512'(bus.bank_q_valid_o), 512'(8'hFF));
        chk("t2_wide_rdy_t0", 512'(bus.wide_q_ready_o), 512'(0));
        chk("t2_lane3_addr",  512'(bus.bank_q_addr_o[3*32 +: 32]), 512'(32'h2018));
        tick();
        bus.bank_q_ready_i = 8'h00;
        settle();
        chk("t2_bank_vld_t1", 512'(bus.bank_q_valid_o), 512'(8'hF0));
        chk("t2_wide_rdy_t1", 512'(bus.wide_q_ready_o), 512'(0));
        tick();
        bus.bank_q_ready_i = 8'hF0;
        settle();
        chk("t2_bank_vld_t2", 512'(bus.bank_q_valid_o), 512'(8'hF0));
        chk("t2_wide_rdy_t2", 512'(bus.wide_q_ready_o), 512'(1));
        tick();
        bus.wide_q_valid_i = 1'b0;
        bus.bank_q_ready_i = 8'hFF;
        settle();
        chk("t2_p_vld_t3",   512'(bus.wide_p_valid_o), 512'(0));
        chk("t2_wide_rdy_t3", 512'(bus.wide_q_ready_o), 512'(0));
        tick();
        settle();
        chk("t2_p_vld_t4",   512'(bus.wide_p_valid_o), 512'(1));
        chk("t2_p_dat_t4",   bus.wide_p_data_o, p2);
        tick();

        // Write touching only lane 0.
        bank_pat = p3;
        bus.wide_q_valid_i = 1'b1;
        bus.wide_q_write_i = 1'b1;
        bus.wide_q_addr_i  = 32'h0000_3000;
        bus.wide_q_strb_i  = 64'h0000_0000_0000_00FF;
        bus.wide_q_data_i  = p4;
        settle();
        chk("t3_bank_vld",   512'(bus.bank_q_valid_o), 512'(8'h01));
        chk("t3_bank_wr",    512'(bus.bank_q_write_o), 512'(8'hFF));
        chk("t3_bank_dat",   bus.bank_q_data_o, p4);
        chk("t3_bank_strb",  512'(bus.bank_q_strb_o), 512'(64'hFF));
        chk("t3_wide_rdy",   512'(bus.wide_q_ready_o), 512'(1));
        tick();
        bus.wide_q_valid_i = 1'b0;
        settle();
        chk("t3_p_vld_t1",   512'(bus.wide_p_valid_o), 512'(0));
        tick();
        settle();
        chk("t3_p_vld_t2",   512'(bus.wide_p_valid_o), 512'(1));
        chk("t3_p_dat_t2",   bus.wide_p_data_o, 512'(0));
        tick();

        // Write with no strobes: no bank traffic, response next cycle.
        bus.wide_q_valid_i = 1'b1;
        bus.wide_q_strb_i  = '0;
        settle();
        chk("t4_bank_vld",   512'(bus.bank_q_valid_o), 512'(0));
        chk("t4_wide_rdy",   512'(bus.wide_q_ready_o), 512'(1));
        tick();
        bus.wide_q_valid_i = 1'b0;
        settle();
        chk("t4_p_vld_t1",   512'(bus.wide_p_valid_o), 512'(1));
        chk("t4_p_dat_t1",   bus.wide_p_data_o, 512'(0));
        tick();
        settle();
        chk("t4_p_vld_t2",   512'(bus.wide_p_valid_o), 512'(0));

        // Reset while collecting: the transaction is dropped.
        bank_pat = p5;
        bus.wide_q_valid_i = 1'b1;
        bus.wide_q_write_i = 1'b0;
        bus.wide_q_strb_i  = '1;
        bus.wide_q_addr_i  = 32'h0000_4000;
        settle();
        chk("t5_wide_rdy",   512'(bus.wide_q_ready_o), 512'(1));
        tick();
        bus.wide_q_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("t5_p_vld_t2",   512'(bus.wide_p_valid_o), 512'(0));
        chk("t5_p_dat_t2",   bus.wide_p_data_o, 512'(0));
        tick();
        settle();
        chk("t5_p_vld_t3",   512'(bus.wide_p_valid_o), 512'(0));
        tick();
        settle();
        chk("t5_p_vld_t4",   512'(bus.wide_p_valid_o), 512'(0));

        // Next read completes normally after the abandoned one.
        bank_pat = p3;
        bus.wide_q_valid_i = 1'b1;
        bus.wide_q_addr_i  = 32'h0000_4040;
        settle();
        chk("t5b_wide_rdy",  512'(bus.wide_q_ready_o), 512'(1));
        tick();
        bus.wide_q_valid_i = 1'b0;
        tick();
        settle();
        chk("t5b_p_vld",     512'(bus.wide_p_valid_o), 512'(1));
        chk("t5b_p_dat",     bus.wide_p_data_o, p3);
        tick();

        // Back-to-back reads with valid held throughout.
        bank_pat = p4;
        bus.wide_q_valid_i = 1'b1;
        bus.wide_q_addr_i  = 32'h0000_5000;
        settle();
        chk("t6_wide_rdy_t0", 512'(bus.wide_q_ready_o), 512'(1));
        tick();
        bus.wide_q_addr_i  = 32'h0000_6000;
        settle();
        chk("t6_wide_rdy_t1", 512'(bus.wide_q_ready_o), 512'(0));
        chk("t6_bank_vld_t1", 512'(bus.bank_q_valid_o), 512'(0));
        tick();
        bank_pat = p5;
        settle();
        chk("t6_wide_rdy_t2", 512'(bus.wide_q_ready_o), 512'(0));
        chk("t6_p_vld_t2",    512'(bus.wide_p_valid_o), 512'(1));
        chk("t6_p_dat_t2",    bus.wide_p_data_o, p4);
        tick();
        settle();
        chk("t6_wide_rdy_t3", 512'(bus.wide_q_ready_o), 512'(1));
        chk("t6_lane7_addr",  512'(bus.bank_q_addr_o[7*32 +: 32]), 512'(32'h6038));
        tick();
        bus.wide_q_valid_i = 1'b0;
        settle();
        chk("t6_p_vld_t4",    512'(bus.wide_p_valid_o), 512'(0));
        tick();
        settle();
        chk("t6_p_vld_t5",    512'(bus.wide_p_valid_o), 512'(1));
        chk("t6_p_dat_t5",    bus.wide_p_data_o, p5);
        tick();
        settle();
        chk("t6_p_vld_t6",    512'(bus.wide_p_valid_o), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
